// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and packet layout for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One display packet per digit: {enable, value[3:0], decimal point}
    localparam int DIGIT_PKT_W = 6;
    localparam int PKT_EN      = 5;
    localparam int PKT_VAL_HI  = 4;
    localparam int PKT_VAL_LO  = 1;
    localparam int PKT_DP      = 0;
    localparam int PKT_VAL_W   = PKT_VAL_HI - PKT_VAL_LO + 1;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Add-3 correction for digits >= 5; result never exceeds 12
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding
// the 8-digit display driver. Produces packed BCD, an overflow flag and
// per-digit display packets with optional leading-zero blanking.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH  = 8,
    parameter int NUM_DIGITS = 3,
    parameter int BLANK_LZ   = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [BIN_WIDTH-1:0]              bin_i,
    input  logic                              start_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              ovf_o,
    output logic [4*NUM_DIGITS-1:0]           bcd_o,
    output logic [DIGIT_PKT_W*NUM_DIGITS-1:0] digits_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int SHW   = BCD_W + BIN_WIDTH + 1;
    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

    state_t                 state_r;
    state_t                 next_state_s;
    logic [BIN_WIDTH-1:0]   shift_r;
    logic [BIN_WIDTH-1:0]   cap_r;
    logic [BIN_WIDTH-1:0]   last_r;
    logic [BCD_W-1:0]       scratch_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   sticky_r;
    logic [BCD_W-1:0]       bcd_r;
    logic                   ovf_r;
    logic                   busy_r;
    logic                   done_r;

    logic [BCD_W-1:0]       adj_s;
    logic [SHW-1:0]         shifted_s;
    logic [BCD_W-1:0]       scratch_next_s;
    logic [BIN_WIDTH-1:0]   shift_next_s;
    logic                   final_ovf_s;
    logic                   cont_trig_s;
    logic                   any_nz_s;
    logic                   en_s;
    logic [DIGIT_PKT_W*NUM_DIGITS-1:0] digits_s;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_r[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // One step of the {scratch, binary} left shift; the top bit leaving the
    // scratch means the value no longer fits in NUM_DIGITS decimal digits
    always_comb begin
        shifted_s      = {adj_s, shift_r, 1'b0};
        scratch_next_s = shifted_s[SHW-2:BIN_WIDTH];
        shift_next_s   = shifted_s[BIN_WIDTH-1:0];
        final_ovf_s    = sticky_r | shifted_s[SHW-1];
    end

    // Next-state decode; in continuous mode a changed input starts a conversion
    always_comb begin
        next_state_s = state_r;
        cont_trig_s  = (CONTINUOUS != 0) && (bin_i != last_r);
        case (state_r)
            IDLE: begin
                if (start_i || cont_trig_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; results land on entry to DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            cap_r     <= '0;
            last_r    <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            sticky_r  <= 1'b0;
            bcd_r     <= '0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == SHIFT);
            done_r  <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (next_state_s == SHIFT) begin
                        shift_r   <= bin_i;
                        cap_r     <= bin_i;
                        scratch_r <= '0;
                        cnt_r     <= CNT_W'(BIN_WIDTH);
                        sticky_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_next_s;
                    shift_r   <= shift_next_s;
                    cnt_r     <= cnt_r - CNT_W'(1);
                    sticky_r  <= final_ovf_s;
                    if (next_state_s == DONE) begin
                        bcd_r  <= final_ovf_s ? ALL_NINES : scratch_next_s;
                        ovf_r  <= final_ovf_s;
                        last_r <= cap_r;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Display packets from the held BCD result, blanking leading zeros
    always_comb begin
        digits_s = '0;
        any_nz_s = 1'b0;
        en_s     = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            any_nz_s = any_nz_s | (bcd_r[4*k +: 4] != 4'd0);
            en_s     = (BLANK_LZ == 0) || (k == 0) || any_nz_s;
            digits_s[DIGIT_PKT_W*k + PKT_EN]                 = en_s;
            digits_s[DIGIT_PKT_W*k + PKT_VAL_LO +: PKT_VAL_W] = bcd_r[4*k +: 4];
            digits_s[DIGIT_PKT_W*k + PKT_DP]                 = 1'b1;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign ovf_o    = ovf_r;
    assign bcd_o    = bcd_r;
    assign digits_o = digits_s;

endmodule
